// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared constants and types for the register-file ALU sequencer.
//   DATA_W / ADDR_W : fixed register-file data and address widths.
//   OP_*            : micro-command opcode encodings carried on CMD_OP.
//   state_e         : sequencer FSM states.
package rf_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;

  localparam logic [0:1] OP_ADD = 2'b00;
  localparam logic [0:1] OP_SUB = 2'b01;
  localparam logic [0:1] OP_AND = 2'b10;
  localparam logic [0:1] OP_LDI = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StCapt  = 2'd2,
    StWrite = 2'd3
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: purely combinational 4-bit ALU for the register-file sequencer.
// Ports:
//   op_i     : opcode (ADD/SUB/AND/LDI)
//   a_i, b_i : source operands
//   imm_i    : immediate, used only by LDI
//   result_o : low 4 bits of the operation
//   carry_o  : ADD carry-out, SUB borrow (a < b), 0 otherwise
//   zero_o   : result equals zero
// All vectors are [0:N] with bit 0 as the MSB.
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  logic [0:1]        op_i,
  input  logic [0:DATA_W-1] a_i,
  input  logic [0:DATA_W-1] b_i,
  input  logic [0:DATA_W-1] imm_i,
  output logic [0:DATA_W-1] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  // One extra bit on the left: wide[0] is the carry (ADD) or the borrow (SUB).
  logic [0:DATA_W] wide;

  always_comb begin
    wide    = '0;
    carry_o = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        wide    = {1'b0, a_i} + {1'b0, b_i};
        carry_o = wide[0];
      end
      OP_SUB: begin
        // Wrap-around in the 5-bit space sets wide[0] exactly when a_i < b_i.
        wide    = {1'b0, a_i} - {1'b0, b_i};
        carry_o = wide[0];
      end
      OP_AND: begin
        wide = {1'b0, a_i & b_i};
      end
      OP_LDI: begin
        wide = {1'b0, imm_i};
      end
      default: begin
        wide = '0;
      end
    endcase
  end

  assign result_o = wide[1:DATA_W];
  assign zero_o   = (result_o == '0);

endmodule

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: command-driven master of a 4-entry x 4-bit register file.
// Accepts one micro-command per valid/ready handshake, reads up to two source
// registers, runs them through rf_seq_alu and writes the result back.
// Ports:
//   CLK, RST_N                   : clock, synchronous active-low reset
//   CMD_VALID / CMD_READY        : command handshake (ready only in IDLE)
//   CMD_OP, CMD_RS, CMD_RT,
//   CMD_RD, CMD_IMM              : command fields
//   RS, RT / CRS, CRT            : register-file read address / read data
//                                  (data valid one cycle after address)
//   RW, DW, RG_WE                : register-file write address/data/strobe
//   DONE                         : one-cycle completion pulse, with RG_WE
//   CARRY, ZERO                  : flags of the last completed command
// Every output is a register; vectors are [0:N] with bit 0 as the MSB.
module rf_alu_sequencer
  import rf_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [0:1]        CMD_OP,
  input  logic [0:ADDR_W-1] CMD_RS,
  input  logic [0:ADDR_W-1] CMD_RT,
  input  logic [0:ADDR_W-1] CMD_RD,
  input  logic [0:DATA_W-1] CMD_IMM,
  output logic [0:ADDR_W-1] RS,
  output logic [0:ADDR_W-1] RT,
  input  logic [0:DATA_W-1] CRS,
  input  logic [0:DATA_W-1] CRT,
  output logic [0:ADDR_W-1] RW,
  output logic [0:DATA_W-1] DW,
  output logic              RG_WE,
  output logic              DONE,
  output logic              CARRY,
  output logic              ZERO
);

  state_e state_q, state_d;

  // Latched command fields still needed after the IDLE cycle. Source
  // addresses go straight into the RS/RT registers; the immediate is consumed
  // in the accept cycle, so neither needs a separate latch.
  logic [0:1]        op_q;
  logic [0:ADDR_W-1] rd_q;

  // Output registers and their next-state values.
  logic              ready_q, ready_d;
  logic [0:ADDR_W-1] rs_q, rs_d;
  logic [0:ADDR_W-1] rt_q, rt_d;
  logic [0:ADDR_W-1] rw_q, rw_d;
  logic [0:DATA_W-1] dw_q, dw_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic              cmd_is_ldi;

  logic [0:1]        alu_op;
  logic [0:DATA_W-1] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign accept     = CMD_VALID && ready_q;
  assign cmd_is_ldi = (CMD_OP == OP_LDI);

  // In IDLE the ALU sees the incoming opcode so an LDI can be written on the
  // very next cycle; in CAPT it sees the latched opcode and the live read data.
  // Capturing CRS/CRT is folded into the DW/flag registers loaded at the end
  // of CAPT, which is what lets the write land one cycle later.
  assign alu_op = (state_q == StIdle) ? CMD_OP : op_q;

  rf_seq_alu u_alu (
    .op_i     (alu_op),
    .a_i      (CRS),
    .b_i      (CRT),
    .imm_i    (CMD_IMM),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = cmd_is_ldi ? StWrite : StRead;
        end
      end
      StRead:  state_d = StCapt;
      StCapt:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_d    = rs_q;
    rt_d    = rt_q;
    rw_d    = rw_q;
    dw_d    = dw_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    // Ready is registered, so it is computed from where the FSM is going.
    ready_d = (state_d == StIdle);

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_is_ldi) begin
            rw_d    = CMD_RD;
            dw_d    = alu_result;
            carry_d = alu_carry;
            zero_d  = alu_zero;
            we_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            rs_d = CMD_RS;
            rt_d = CMD_RT;
          end
        end
      end
      StCapt: begin
        rw_d    = rd_q;
        dw_d    = alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        we_d    = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        // READ and WRITE only hold; the strobes fall back to 0 via defaults.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ready_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rw_q    <= '0;
      dw_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rw_q    <= rw_d;
      dw_q    <= dw_d;
      we_q    <= we_d;
      done_q  <= done_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      op_q <= OP_ADD;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= CMD_OP;
      rd_q <= CMD_RD;
    end
  end

  assign CMD_READY = ready_q;
  assign RS        = rs_q;
  assign RT        = rt_q;
  assign RW        = rw_q;
  assign DW        = dw_q;
  assign RG_WE     = we_q;
  assign DONE      = done_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer: a behavioural register file answers the read
// port, a driver issues directed and random commands, and a reference model
// predicts each write (address, data, flags, cycle) into a scoreboard queue
// that a negedge monitor drains whenever RG_WE is seen.
module tb_rf_alu_sequencer;

  localparam int NEVER = 32'h7fff_ffff;

  logic       CLK;
  logic       RST_N;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [0:1] CMD_OP;
  logic [0:1] CMD_RS;
  logic [0:1] CMD_RT;
  logic [0:1] CMD_RD;
  logic [0:3] CMD_IMM;
  logic [0:1] RS;
  logic [0:1] RT;
  logic [0:3] CRS;
  logic [0:3] CRT;
  logic [0:1] RW;
  logic [0:3] DW;
  logic       RG_WE;
  logic       DONE;
  logic       CARRY;
  logic       ZERO;

  rf_alu_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_RS    (CMD_RS),
    .CMD_RT    (CMD_RT),
    .CMD_RD    (CMD_RD),
    .CMD_IMM   (CMD_IMM),
    .RS        (RS),
    .RT        (RT),
    .CRS       (CRS),
    .CRT       (CRT),
    .RW        (RW),
    .DW        (DW),
    .RG_WE     (RG_WE),
    .DONE      (DONE),
    .CARRY     (CARRY),
    .ZERO      (ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural register file: synchronous read, write on RG_WE.
  logic [3:0] rf [0:3];
  always @(posedge CLK) begin
    CRS <= rf[RS];
    CRT <= rf[RT];
    if (RG_WE) rf[RW] <= DW;
  end

  typedef struct {
    int         cyc;
    logic [1:0] rd;
    logic [3:0] dw;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mregs [0:3];
  int         ready_from = NEVER;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on register values.
  task automatic model(input int op, input int a, input int b, input int imm,
                       output logic [3:0] res, output logic c, output logic z);
    int r;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r >= 16); end
      1: begin r = a - b; c = (a < b); if (r < 0) r += 16; end
      2: r = a & b;
      default: r = imm;
    endcase
    res = 4'(r % 16);
    z   = (res == 4'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(CMD_READY), 32'd0);
    check({tag, "_rs"},    32'(RS),        32'd0);
    check({tag, "_rt"},    32'(RT),        32'd0);
    check({tag, "_rw"},    32'(RW),        32'd0);
    check({tag, "_dw"},    32'(DW),        32'd0);
    check({tag, "_we"},    32'(RG_WE),     32'd0);
    check({tag, "_done"},  32'(DONE),      32'd0);
    check({tag, "_carry"}, 32'(CARRY),     32'd0);
    check({tag, "_zero"},  32'(ZERO),      32'd0);
  endtask

  // Present a command (leaving CMD_VALID high) and return #1 after acceptance.
  task automatic issue(input int op, input int rs, input int rt, input int rd, input int imm);
    exp_t e;
    bit   done_flag;
    done_flag = 0;
    CMD_VALID = 1'b1;
    CMD_OP    = 2'(op);
    CMD_RS    = 2'(rs);
    CMD_RT    = 2'(rt);
    CMD_RD    = 2'(rd);
    CMD_IMM   = 4'(imm);
    for (int i = 0; i < 20 && !done_flag; i++) begin
      if (CMD_READY === 1'b1) begin
        model(op, int'(mregs[rs]), int'(mregs[rt]), imm, e.dw, e.c, e.z);
        e.rd = 2'(rd);
        @(posedge CLK); #1;
        e.cyc = cyc + ((op == 3) ? 0 : 2);
        sb.push_back(e);
        mregs[rd] = e.dw;
        ready_from = cyc + ((op == 3) ? 1 : 3);
        if (op != 3) begin
          check("read_rs", 32'(RS), 32'(rs));
          check("read_rt", 32'(RT), 32'(rt));
        end
        done_flag = 1;
      end else begin
        @(posedge CLK); #1;
      end
    end
    if (!done_flag) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout @cyc %0d: ready %0b, expected 1 within 20 cycles",
               cyc, CMD_READY);
      CMD_VALID = 1'b0;
    end
  endtask

  // Monitor: ready/strobe protocol every cycle, scoreboard pop on each write.
  always @(negedge CLK) begin
    exp_t e;
    check("ready", 32'(CMD_READY), 32'(cyc >= ready_from));
    check("done_eq_we", 32'(DONE), 32'(RG_WE));
    if (RG_WE === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write @cyc %0d: RW=%0d DW=%0h, expected no write", cyc, RW, DW);
      end else begin
        e = sb.pop_front();
        check("we_cycle", 32'(cyc), 32'(e.cyc));
        check("rw", 32'(RW), 32'(e.rd));
        check("dw", 32'(DW), 32'(e.dw));
        check("carry", 32'(CARRY), 32'(e.c));
        check("zero", 32'(ZERO), 32'(e.z));
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_write @cyc %0d: RG_WE=0, expected write to r%0d at cyc %0d",
               cyc, e.rd, e.cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] saved [0:3];
    int         wait_n;
    RST_N     = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = '0;
    CMD_RS    = '0;
    CMD_RT    = '0;
    CMD_RD    = '0;
    CMD_IMM   = '0;

    // Reset held for 3 cycles, then release.
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    RST_N = 1'b1;
    @(posedge CLK); #1;
    ready_from = cyc;
    check("ready_after_release", 32'(CMD_READY), 32'd1);

    // Directed: LDI, then set up operands.
    issue(3, 0, 0, 2, 4'b1011);
    issue(3, 0, 0, 0, 4'b1001);
    issue(3, 0, 0, 1, 4'b1000);
    issue(3, 0, 0, 3, 4'b0000);
    // ADD 1001 + 1000 -> 0001, carry.
    issue(0, 0, 1, 3, 0);
    // SUB r2 - r2 with r2 = 0101 -> 0000, zero.
    issue(3, 0, 0, 2, 4'b0101);
    issue(1, 2, 2, 2, 0);
    // SUB 0011 - 0100 -> 1111, borrow.
    issue(3, 0, 0, 0, 4'b0011);
    issue(3, 0, 0, 1, 4'b0100);
    issue(1, 0, 1, 3, 0);
    // Two ADDs back to back with CMD_VALID held high.
    issue(0, 3, 1, 2, 0);
    issue(0, 2, 0, 1, 0);
    CMD_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    // Reset during CAPT of an ADD: the write must never happen.
    for (int i = 0; i < 4; i++) saved[i] = mregs[i];
    issue(0, 0, 1, 2, 0);
    CMD_VALID = 1'b0;
    @(posedge CLK); #1;
    RST_N      = 1'b0;
    ready_from = NEVER;
    sb.delete();
    for (int i = 0; i < 4; i++) mregs[i] = saved[i];
    @(posedge CLK); #1;
    check_reset_outputs("midrst");
    RST_N = 1'b1;
    @(posedge CLK); #1;
    ready_from = cyc;
    // Verify the aborted write left r2 untouched.
    issue(2, 2, 2, 0, 0);
    CMD_VALID = 1'b0;

    // Random commands with occasional idle gaps.
    for (int n = 0; n < 80; n++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        CMD_VALID = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    CMD_VALID = 1'b0;

    wait_n = 0;
    while (sb.size() > 0 && wait_n < 20) begin
      @(posedge CLK); #1;
      wait_n++;
    end
    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Command-driven initiator for the 4-entry × 4-bit register file port (RS/RT read, RW/DW/RG_WE write). It accepts one micro-command at a time over a valid/ready handshake. For each command it reads up to two source registers, computes a 4-bit ALU result, and writes the result back to a destination register. It sits between the control unit and the register file and is the only master of the register file's address and write-enable inputs.

## Interface
- Parameters: none; widths are fixed (4-bit data, 2-bit register address); all vectors are [0:N], bit 0 = MSB.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  [0:1]  00 ADD, 01 SUB, 10 AND, 11 LDI.
- CMD_RS, CMD_RT, CMD_RD  in  [0:1]  source A, source B, destination register.
- CMD_IMM  in  [0:3]  immediate for LDI.
- RS, RT  out  [0:1]  register file read addresses.
- CRS, CRT  in  [0:3]  register file read data, valid one cycle after RS/RT are driven.
- RW  out  [0:1]  write address.
- DW  out  [0:3]  write data.
- RG_WE  out  1  write strobe, one cycle per command.
- DONE  out  1  one-cycle pulse, coincident with RG_WE.
- CARRY, ZERO  out  1 each  flags of the last completed command; held until the next DONE.

## Operation
- States: IDLE, READ, CAPT, WRITE.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&CMD_READY, latch op/rs/rt/rd/imm.
  - For LDI go to WRITE; otherwise go to READ.
- READ: drive RS=rs, RT=rt; go to CAPT.
- CAPT:
  - Latch CRS→A and CRT→B.
  - Compute the result combinationally.
  - Go to WRITE.
- WRITE:
  - RG_WE=1, RW=rd, DW=result, DONE=1.
  - Update CARRY/ZERO.
  - Go to IDLE.
- Arithmetic (5-bit intermediate, result = low 4 bits, mod 16):
  - ADD: A+B; CARRY = bit 4.
  - SUB: A−B; CARRY = borrow (A<B).
  - AND: A&B; CARRY = 0.
  - LDI: IMM; CARRY = 0.
- ZERO = (result == 0).
- CMD_READY is 0 in every state except IDLE. Commands presented outside IDLE are not accepted and stay pending on the handshake.
- rd may equal rs or rt. The read completes before the write, so the old value is used.
- All outputs are registered. RS/RT/RW/DW hold their last driven value in other states. RG_WE and DONE are 0 outside WRITE.

## Timing
- Reset values: state=IDLE; CMD_READY=0 while RST_N=0, 1 the first cycle after release; RS=RT=RW=00; DW=0000; RG_WE=0; DONE=0; CARRY=0; ZERO=0.
- Accept at edge 0:
  - ADD/SUB/AND: RS/RT valid in cycle 1, CRS/CRT sampled at edge 2, RG_WE/DONE high in cycle 3, CMD_READY high in cycle 4. Throughput is 1 command per 4 cycles.
  - LDI: RG_WE/DONE high in cycle 1, CMD_READY high in cycle 2.
- Reset mid-operation: if RST_N is sampled low at any edge, the next cycle is IDLE with all outputs at their reset values. If reset is sampled at the edge entering WRITE, RG_WE never rises and no write occurs. The latched command is discarded.
- If CMD_VALID stays high in IDLE, back-to-back commands are accepted with no idle gap beyond the IDLE cycle.

## Structure
- Package rf_seq_pkg:
  - Op encodings OP_ADD/OP_SUB/OP_AND/OP_LDI.
  - State encoding.
  - Constants DATA_W=4 and ADDR_W=2.
- Sub-module rf_seq_alu: combinational; inputs op, A, B, imm; outputs result[0:3], carry, zero.
- The top level holds the FSM, command latch, and output registers.

## Test plan
- Reset: hold RST_N=0 for 3 cycles → all outputs at reset values, CMD_READY=0; release → CMD_READY=1 next cycle.
- LDI rd=10, imm=1011 → cycle 1: RG_WE=1, RW=10, DW=1011, DONE=1, CARRY=0, ZERO=0.
- ADD rs=00 (CRS=1001), rt=01 (CRT=1000), rd=11:
  - RS=00/RT=01 in cycle 1.
  - Cycle 3: DW=0001, CARRY=1, ZERO=0.
- SUB with rs=rt=10, both reading 0101, rd=10 → DW=0000, ZERO=1, CARRY=0.
- SUB 0011−0100 → DW=1111, CARRY=1.
- CMD_VALID held high across two ADDs: second accepted only when CMD_READY=1. RG_WE pulses are exactly 4 cycles apart and each is one cycle wide.
- Reset during CAPT of an ADD → RG_WE stays 0 throughout; IDLE follows.
